noc_packet_unpacker: RTL and testbench
======================================

# noc_packet_unpacker

Receive-side endpoint of the NoC flit protocol: consumes a single-VC flit stream, decodes the header flit into discrete header fields, and emits payload flits as a counted beat stream with a generated `pld_last`. It sits between a router's local output port and the network-interface logic of an attached agent. It is the counterpart of the packer that builds flits from header fields and payload. Malformed packets are detected, flagged and drained without ever deadlocking the input.

## Interface
- `CONFIG`, default `NOC_DEFAULT_CONFIG`: `noc_config` struct supplying all field widths (address, data, id_x/y, vc, tag, length).
- `ERR_CNT_WIDTH`, default 16: width of the saturating error counter.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `flit_valid`  in  1  input flit valid.
- `flit_ready`  out  1  input flit accept.
- `flit_type`  in  1  0 = header, 1 = payload.
- `flit_tail`  in  1  last flit of the packet.
- `flit_data`  in  data_width  flit body.
- `hdr_valid`  out  1  header output valid.
- `hdr_ready`  in  1  header output accept.
- `hdr_type`  out  8  packet type; bit 7 = has_payload.
- `hdr_dst_x`, `hdr_dst_y`, `hdr_src_x`, `hdr_src_y`  out  id_x/id_y  routing IDs.
- `hdr_vc`  out  vc_width  virtual channel.
- `hdr_tag`  out  tag_width  transaction tag.
- `hdr_length`  out  length_width  payload length code.
- `hdr_address`  out  address_width  address.
- `pld_valid`, `pld_ready`  out/in  1  payload handshake.
- `pld_data`  out  data_width  payload beat.
- `pld_last`  out  1  final beat of the packet.
- `err_pulse`  out  1  one-cycle error strobe.
- `err_code`  out  2  error kind, valid with `err_pulse`.
- `err_count`  out  ERR_CNT_WIDTH  saturating error count.

## Operation
- Header layout in `flit_data`, LSB first: type[8], dst_x, dst_y, src_x, src_y, vc, tag, length, address. The total width must be ≤ data_width; this is checked by an elaboration-time assertion.
- Beat count: L = length. Beats = 2^length_width when L = 0, otherwise L. Only applies when has_payload = 1.
- FSM states:
  - IDLE: waits for a header flit.
    - Valid header with has_payload = 0 and tail = 1: load the header register, stay in IDLE.
    - Valid header with has_payload = 1 and tail = 0: load the header register, load the counter with the beat count, go to PAYLOAD.
    - Header with has_payload = 0 and tail = 0: err_code 2, no header output, go to DRAIN.
    - Header with has_payload = 1 and tail = 1: err_code 2, dropped, stay in IDLE.
    - Payload flit: err_code 0, consumed and dropped.
  - PAYLOAD: each accepted payload flit loads the payload slice and decrements the counter.
    - Counter reaches 1 with tail = 1: `pld_last` = 1, go to IDLE.
    - Tail = 1 while counter > 1: `pld_last` forced to 1, err_code 1, go to IDLE.
    - Counter reaches 1 with tail = 0: `pld_last` = 1, err_code 1, go to DRAIN.
    - Header flit: err_code 3, consumed and dropped, state unchanged.
  - DRAIN: accepts and discards all flits until a tail flit, then goes to IDLE. No errors are raised while draining.
- Header and payload channels are independent: payload beats may be presented before the header handshake completes.
- `err_count` increments on each `err_pulse` and saturates at all-ones.

## Timing
- Reset values: state IDLE; `hdr_valid` 0; `pld_valid` 0; `pld_last` 0; `err_pulse` 0; `err_code` 0; `err_count` 0. Header and payload data registers are reset to 0.
- A flit accepted in cycle N appears on the header or payload output at N+1. `err_pulse` is asserted in N+1.
- `flit_ready` per state:
  - IDLE: !hdr_valid || hdr_ready.
  - PAYLOAD: (!pld_valid || pld_ready) for payload flits; 1 for stray header flits.
  - DRAIN: 1.
- Throughput is one flit per cycle with back-to-back packets when the consumers are always ready.
- The output valid signals hold, with stable data, until their ready is seen.
- Reset asserted mid-packet takes priority over everything: all state returns to reset values on the next edge.

## Structure
- Shared package `noc_packet_pkg` (imports `noc_config_pkg`) holds:
  - the `noc_flit_type` enum;
  - the `noc_header` field struct, built from the config widths;
  - the `noc_unpack_error` enum (STRAY_PAYLOAD = 0, LENGTH_MISMATCH = 1, BAD_HEADER = 2, STRAY_HEADER = 3);
  - the beat-count function.
- One sub-module, `noc_payload_slice`: a single-entry valid/ready register slice carrying data and last. The FSM, counter and header register stay in the top module.

## Test plan
- Header-only packet (type 0x01, tail = 1, address 0x1000) with hdr_ready held at 1 → `hdr_valid` pulses 1 cycle at N+1 with address 0x1000; no payload beats.
- Header with has_payload, length 4, then 4 payload flits (tail on the 4th), consumers always ready → 4 payload beats on consecutive cycles, `pld_last` on beat 4, no error.
- length 0 with length_width 5 → 32 beats accepted, `pld_last` on beat 32.
- Length 4 with tail on beat 2 → `pld_last` on beat 2, err_code 1, `err_count` = 1, next header accepted normally.
- Length 2 with no tail until beat 5 → `pld_last` on beat 2; beats 3–5 dropped in DRAIN; one error, err_code 1.
- Payload flit arriving in IDLE, then `hdr_ready` held at 0 for 10 cycles → err_code 0 for the stray flit; the second header stalls (`flit_ready` = 0) until `hdr_ready` rises.

Source files
------------

// File: rtl/noc_config_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_config_pkg
// Description : NoC-wide field-width configuration. Each NoC block takes one
//               noc_config struct as a parameter and derives its widths from it.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_config_pkg;

    typedef struct packed {
        int unsigned address_width;
        int unsigned data_width;
        int unsigned id_x_width;
        int unsigned id_y_width;
        int unsigned vc_width;
        int unsigned tag_width;
        int unsigned length_width;
    } noc_config;

    // Header = 8 + 2+2+2+2 + 2 + 6 + 5 + 32 = 61 bits, fits a 64-bit flit.
    localparam noc_config NOC_DEFAULT_CONFIG = '{
        address_width : 32,
        data_width    : 64,
        id_x_width    : 2,
        id_y_width    : 2,
        vc_width      : 2,
        tag_width     : 6,
        length_width  : 5
    };

endpackage : noc_config_pkg
`default_nettype wire

// File: rtl/noc_packet_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_packet_pkg
// Description : Flit-protocol types shared by the packer and the unpacker:
//               flit type, header field struct, unpacker error codes, FSM
//               state encoding and the payload beat-count rule.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_packet_pkg;

    import noc_config_pkg::*;

    typedef enum logic {
        NOC_FLIT_HEADER  = 1'b0,
        NOC_FLIT_PAYLOAD = 1'b1
    } noc_flit_type;

    typedef enum logic [1:0] {
        STRAY_PAYLOAD   = 2'd0,
        LENGTH_MISMATCH = 2'd1,
        BAD_HEADER      = 2'd2,
        STRAY_HEADER    = 2'd3
    } noc_unpack_error;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DRAIN   = 2'd2
    } noc_unpack_state;

    localparam int unsigned C_HDR_TYPE_WIDTH  = 8;
    localparam int unsigned C_HAS_PAYLOAD_BIT = 7;

    localparam int unsigned C_DEF_AW  = NOC_DEFAULT_CONFIG.address_width;
    localparam int unsigned C_DEF_IXW = NOC_DEFAULT_CONFIG.id_x_width;
    localparam int unsigned C_DEF_IYW = NOC_DEFAULT_CONFIG.id_y_width;
    localparam int unsigned C_DEF_VCW = NOC_DEFAULT_CONFIG.vc_width;
    localparam int unsigned C_DEF_TW  = NOC_DEFAULT_CONFIG.tag_width;
    localparam int unsigned C_DEF_LW  = NOC_DEFAULT_CONFIG.length_width;

    // Packed MSB-first, so the first member (address) sits at the top of the
    // flit and ptype at bit 0: identical to the LSB-first wire layout.
    typedef struct packed {
        logic [C_DEF_AW-1:0]         address;
        logic [C_DEF_LW-1:0]         length;
        logic [C_DEF_TW-1:0]         tag;
        logic [C_DEF_VCW-1:0]        vc;
        logic [C_DEF_IYW-1:0]        src_y;
        logic [C_DEF_IXW-1:0]        src_x;
        logic [C_DEF_IYW-1:0]        dst_y;
        logic [C_DEF_IXW-1:0]        dst_x;
        logic [C_HDR_TYPE_WIDTH-1:0] ptype;
    } noc_header;

    // A length code of 0 encodes the largest packet (2^length_width beats).
    function automatic int unsigned noc_beat_count(input int unsigned length,
                                                   input int unsigned length_width);
        if (length == 0) begin
            return 32'd1 << length_width;
        end
        return length;
    endfunction

endpackage : noc_packet_pkg
`default_nettype wire

// File: rtl/noc_payload_slice.sv
`default_nettype none
// ============================================================================
// Module      : noc_payload_slice
// Description : Single-entry valid/ready register slice carrying a data word
//               and a last flag. Accepts a new word in the same cycle the held
//               one is taken, so it sustains one beat per cycle.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_in_*          - upstream valid/ready/data/last
//               o_out_*, i_out_ready - downstream valid/data/last/ready
// Revision    : 1.0 - initial release
// ============================================================================
module noc_payload_slice #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    input  logic                  i_in_last,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic                  o_out_last
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;

    assign o_in_ready  = !r_valid || i_out_ready;
    assign o_out_valid = r_valid;
    assign o_out_data  = r_data;
    // Only meaningful alongside valid; masked so it never lingers after a beat.
    assign o_out_last  = r_valid && r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_in_valid && o_in_ready) begin
            r_valid <= 1'b1;
            r_data  <= i_in_data;
            r_last  <= i_in_last;
        end else if (i_out_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule : noc_payload_slice
`default_nettype wire

// File: rtl/noc_packet_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : noc_packet_unpacker
// Description : Receive-side NoC endpoint. Decodes header flits into discrete
//               fields, turns payload flits into a counted beat stream with a
//               generated pld_last, and flags/drains malformed packets.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               flit_*              - input flit stream (valid/ready/type/tail/data)
//               hdr_*               - decoded header output (valid/ready + fields)
//               pld_*               - payload beat output (valid/ready/data/last)
//               err_pulse/code      - one-cycle error strobe and its kind
//               err_count           - saturating error count
// Revision    : 1.0 - initial release
// ============================================================================
module noc_packet_unpacker
    import noc_config_pkg::*;
    import noc_packet_pkg::*;
#(
    parameter noc_config   CONFIG        = NOC_DEFAULT_CONFIG,
    parameter int unsigned ERR_CNT_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flit_valid,
    output logic                              flit_ready,
    input  logic                              flit_type,
    input  logic                              flit_tail,
    input  logic [CONFIG.data_width-1:0]      flit_data,
    output logic                              hdr_valid,
    input  logic                              hdr_ready,
    output logic [7:0]                        hdr_type,
    output logic [CONFIG.id_x_width-1:0]      hdr_dst_x,
    output logic [CONFIG.id_y_width-1:0]      hdr_dst_y,
    output logic [CONFIG.id_x_width-1:0]      hdr_src_x,
    output logic [CONFIG.id_y_width-1:0]      hdr_src_y,
    output logic [CONFIG.vc_width-1:0]        hdr_vc,
    output logic [CONFIG.tag_width-1:0]       hdr_tag,
    output logic [CONFIG.length_width-1:0]    hdr_length,
    output logic [CONFIG.address_width-1:0]   hdr_address,
    output logic                              pld_valid,
    input  logic                              pld_ready,
    output logic [CONFIG.data_width-1:0]      pld_data,
    output logic                              pld_last,
    output logic                              err_pulse,
    output logic [1:0]                        err_code,
    output logic [ERR_CNT_WIDTH-1:0]          err_count
);

    localparam int unsigned DW    = CONFIG.data_width;
    localparam int unsigned AW    = CONFIG.address_width;
    localparam int unsigned IXW   = CONFIG.id_x_width;
    localparam int unsigned IYW   = CONFIG.id_y_width;
    localparam int unsigned VCW   = CONFIG.vc_width;
    localparam int unsigned TW    = CONFIG.tag_width;
    localparam int unsigned LW    = CONFIG.length_width;
    localparam int unsigned HDR_W = C_HDR_TYPE_WIDTH + 2 * IXW + 2 * IYW + VCW + TW + LW + AW;
    // One extra bit so the length-0 case (2^LW beats) is representable.
    localparam int unsigned CNTW  = LW + 1;

    // Same layout as noc_packet_pkg::noc_header, sized from this instance's CONFIG.
    typedef struct packed {
        logic [AW-1:0]               address;
        logic [LW-1:0]               length;
        logic [TW-1:0]               tag;
        logic [VCW-1:0]              vc;
        logic [IYW-1:0]              src_y;
        logic [IXW-1:0]              src_x;
        logic [IYW-1:0]              dst_y;
        logic [IXW-1:0]              dst_x;
        logic [C_HDR_TYPE_WIDTH-1:0] ptype;
    } hdr_t;

    if (HDR_W > DW) begin : g_hdr_width_check
        $error("noc_packet_unpacker: header needs %0d bits, flit has %0d", HDR_W, DW);
    end

    noc_unpack_state  r_state;
    noc_unpack_state  w_state_nxt;

    hdr_t             w_hdr;
    hdr_t             r_hdr;
    logic             r_hdr_valid;
    logic [CNTW-1:0]  r_cnt;
    logic [CNTW-1:0]  w_beats;

    logic             w_is_payload;
    logic             w_has_payload;
    logic             w_flit_ready;
    logic             w_hdr_load;
    logic             w_cnt_load;
    logic             w_cnt_dec;
    logic             w_pld_push;
    logic             w_pld_last;
    logic             w_slice_in_ready;
    logic             w_err;
    noc_unpack_error  w_err_code;

    logic                     r_err_pulse;
    noc_unpack_error          r_err_code;
    logic [ERR_CNT_WIDTH-1:0] r_err_count;

    assign w_hdr         = flit_data[HDR_W-1:0];
    assign w_is_payload  = (noc_flit_type'(flit_type) == NOC_FLIT_PAYLOAD);
    assign w_has_payload = w_hdr.ptype[C_HAS_PAYLOAD_BIT];
    assign w_beats       = CNTW'(noc_beat_count(32'(w_hdr.length), LW));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, flit acceptance and datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_flit_ready = 1'b0;
        w_hdr_load   = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        w_pld_push   = 1'b0;
        w_pld_last   = 1'b0;
        w_err        = 1'b0;
        w_err_code   = STRAY_PAYLOAD;

        case (r_state)
            ST_IDLE: begin
                // Everything in IDLE, including flits that end up dropped,
                // waits for header-register space so error ordering stays
                // tied to header delivery.
                w_flit_ready = !r_hdr_valid || hdr_ready;
                if (flit_valid && w_flit_ready) begin
                    if (w_is_payload) begin
                        w_err      = 1'b1;
                        w_err_code = STRAY_PAYLOAD;
                    end else if (w_has_payload == flit_tail) begin
                        // Payload-bearing header marked tail, or header-only
                        // packet without tail: neither is a legal packet.
                        w_err      = 1'b1;
                        w_err_code = BAD_HEADER;
                        if (!flit_tail) begin
                            w_state_nxt = ST_DRAIN;
                        end
                    end else begin
                        w_hdr_load = 1'b1;
                        if (w_has_payload) begin
                            w_cnt_load  = 1'b1;
                            w_state_nxt = ST_PAYLOAD;
                        end
                    end
                end
            end

            ST_PAYLOAD: begin
                // Stray headers are swallowed without waiting on the slice.
                w_flit_ready = w_is_payload ? w_slice_in_ready : 1'b1;
                if (flit_valid && w_flit_ready) begin
                    if (!w_is_payload) begin
                        w_err      = 1'b1;
                        w_err_code = STRAY_HEADER;
                    end else begin
                        w_pld_push = 1'b1;
                        w_cnt_dec  = 1'b1;
                        if (r_cnt == CNTW'(1)) begin
                            w_pld_last = 1'b1;
                            if (flit_tail) begin
                                w_state_nxt = ST_IDLE;
                            end else begin
                                w_err       = 1'b1;
                                w_err_code  = LENGTH_MISMATCH;
                                w_state_nxt = ST_DRAIN;
                            end
                        end else if (flit_tail) begin
                            // Early tail: close the burst cleanly for the consumer.
                            w_pld_last  = 1'b1;
                            w_err       = 1'b1;
                            w_err_code  = LENGTH_MISMATCH;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
            end

            ST_DRAIN: begin
                w_flit_ready = 1'b1;
                if (flit_valid && flit_tail) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign flit_ready = w_flit_ready;

    // ------------------------------------------------------------------
    // Header register and beat counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hdr_valid <= 1'b0;
            r_hdr       <= '0;
        end else if (w_hdr_load) begin
            r_hdr_valid <= 1'b1;
            r_hdr       <= w_hdr;
        end else if (hdr_ready) begin
            r_hdr_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_cnt_load) begin
            r_cnt <= w_beats;
        end else if (w_cnt_dec) begin
            r_cnt <= r_cnt - CNTW'(1);
        end
    end

    assign hdr_valid   = r_hdr_valid;
    assign hdr_type    = r_hdr.ptype;
    assign hdr_dst_x   = r_hdr.dst_x;
    assign hdr_dst_y   = r_hdr.dst_y;
    assign hdr_src_x   = r_hdr.src_x;
    assign hdr_src_y   = r_hdr.src_y;
    assign hdr_vc      = r_hdr.vc;
    assign hdr_tag     = r_hdr.tag;
    assign hdr_length  = r_hdr.length;
    assign hdr_address = r_hdr.address;

    // ------------------------------------------------------------------
    // Error strobe and saturating counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_pulse <= 1'b0;
            r_err_code  <= STRAY_PAYLOAD;
            r_err_count <= '0;
        end else begin
            r_err_pulse <= w_err;
            if (w_err) begin
                r_err_code <= w_err_code;
                if (r_err_count != {ERR_CNT_WIDTH{1'b1}}) begin
                    r_err_count <= r_err_count + ERR_CNT_WIDTH'(1);
                end
            end
        end
    end

    assign err_pulse = r_err_pulse;
    assign err_code  = r_err_code;
    assign err_count = r_err_count;

    // ------------------------------------------------------------------
    // Payload output slice
    // ------------------------------------------------------------------
    noc_payload_slice #(
        .DATA_WIDTH (DW)
    ) u_payload_slice (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (w_pld_push),
        .o_in_ready  (w_slice_in_ready),
        .i_in_data   (flit_data),
        .i_in_last   (w_pld_last),
        .o_out_valid (pld_valid),
        .i_out_ready (pld_ready),
        .o_out_data  (pld_data),
        .o_out_last  (pld_last)
    );

endmodule : noc_packet_unpacker
`default_nettype wire

// File: tb/tb_noc_packet_unpacker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_noc_packet_unpacker
// Description : Directed self-checking bench for noc_packet_unpacker with the
//               default configuration (64-bit flits, 5-bit length code).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_packet_unpacker;

    logic        clk = 1'b0;
    logic        rst;
    logic        flit_valid;
    logic        flit_ready;
    logic        flit_type;
    logic        flit_tail;
    logic [63:0] flit_data;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [7:0]  hdr_type;
    logic [1:0]  hdr_dst_x, hdr_dst_y, hdr_src_x, hdr_src_y;
    logic [1:0]  hdr_vc;
    logic [5:0]  hdr_tag;
    logic [4:0]  hdr_length;
    logic [31:0] hdr_address;
    logic        pld_valid;
    logic        pld_ready;
    logic [63:0] pld_data;
    logic        pld_last;
    logic        err_pulse;
    logic [1:0]  err_code;
    logic [15:0] err_count;

    always #5 clk = ~clk;

    noc_packet_unpacker dut (
        .clk         (clk),
        .rst         (rst),
        .flit_valid  (flit_valid),
        .flit_ready  (flit_ready),
        .flit_type   (flit_type),
        .flit_tail   (flit_tail),
        .flit_data   (flit_data),
        .hdr_valid   (hdr_valid),
        .hdr_ready   (hdr_ready),
        .hdr_type    (hdr_type),
        .hdr_dst_x   (hdr_dst_x),
        .hdr_dst_y   (hdr_dst_y),
        .hdr_src_x   (hdr_src_x),
        .hdr_src_y   (hdr_src_y),
        .hdr_vc      (hdr_vc),
        .hdr_tag     (hdr_tag),
        .hdr_length  (hdr_length),
        .hdr_address (hdr_address),
        .pld_valid   (pld_valid),
        .pld_ready   (pld_ready),
        .pld_data    (pld_data),
        .pld_last    (pld_last),
        .err_pulse   (err_pulse),
        .err_code    (err_code),
        .err_count   (err_count)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- output monitor (samples on falling edge) ----------------
    int          cyc    = 0;
    int          beat_n = 0;
    int          hdr_n  = 0;
    int          err_n  = 0;
    logic [63:0] beat_data[$];
    bit          beat_last[$];
    int          beat_cyc[$];
    logic [31:0] hdr_addr_last = '0;
    logic [1:0]  err_code_last = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (pld_valid && pld_ready) begin
                beat_data.push_back(pld_data);
                beat_last.push_back(pld_last);
                beat_cyc.push_back(cyc);
                beat_n++;
            end
            if (hdr_valid && hdr_ready) begin
                hdr_n++;
                hdr_addr_last = hdr_address;
            end
            if (err_pulse) begin
                err_n++;
                err_code_last = err_code;
            end
        end
    end

    // Hand layout: type[7:0] dx[9:8] dy[11:10] sx[13:12] sy[15:14] vc[17:16]
    // tag[23:18] len[28:24] addr[60:29]
    function automatic logic [63:0] mk_hdr(input logic [7:0] typ, input logic [4:0] len,
                                           input logic [31:0] addr, input logic [5:0] tag);
        logic [63:0] d;
        d        = '0;
        d[7:0]   = typ;
        d[9:8]   = 2'd1;
        d[11:10] = 2'd2;
        d[13:12] = 2'd3;
        d[15:14] = 2'd0;
        d[17:16] = 2'd1;
        d[23:18] = tag;
        d[28:24] = len;
        d[60:29] = addr;
        return d;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one flit and returns #1 after the edge that accepted it.
    task automatic send(input logic t, input logic tail, input logic [63:0] d);
        int n;
        n          = 0;
        flit_valid = 1'b1;
        flit_type  = t;
        flit_tail  = tail;
        flit_data  = d;
        forever begin
            @(negedge clk);
            if (flit_ready) break;
            n++;
            if (n > 200) begin
                check("send_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        flit_valid = 1'b0;
    endtask

    task automatic check_burst(input string tag, input int b0, input int nexp,
                               input int last_at, input bit contiguous);
        int n;
        int lasts;
        int last_idx;
        n        = beat_n - b0;
        lasts    = 0;
        last_idx = -1;
        check({tag, "_beats"}, n, nexp);
        for (int i = 0; i < n; i++) begin
            if (beat_last[b0 + i]) begin
                lasts++;
                if (last_idx < 0) last_idx = i + 1;
            end
        end
        check({tag, "_last_cnt"}, lasts, 1);
        check({tag, "_last_at"}, last_idx, last_at);
        if (contiguous && n > 0) begin
            check({tag, "_gap"}, beat_cyc[b0 + n - 1] - beat_cyc[b0], n - 1);
        end
    endtask

    initial begin
        int b0, h0, e0, stalls;

        rst        = 1'b1;
        flit_valid = 1'b0;
        flit_type  = 1'b0;
        flit_tail  = 1'b0;
        flit_data  = '0;
        hdr_ready  = 1'b1;
        pld_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_hdr_valid", hdr_valid, 0);
        check("rst_pld_valid", pld_valid, 0);
        check("rst_pld_last", pld_last, 0);
        check("rst_err_pulse", err_pulse, 0);
        check("rst_err_code", err_code, 0);
        check("rst_err_count", err_count, 0);
        check("rst_hdr_address", hdr_address, 0);
        check("rst_flit_ready", flit_ready, 1);
        @(posedge clk);
        #1;

        // ---- header-only packet ----
        b0 = beat_n; e0 = err_n;
        send(1'b0, 1'b1, mk_hdr(8'h01, 5'd0, 32'h1000, 6'h05));
        check("t1_hdr_valid", hdr_valid, 1);
        check("t1_address", hdr_address, 32'h1000);
        check("t1_type", hdr_type, 8'h01);
        check("t1_ids", {hdr_dst_x, hdr_dst_y, hdr_src_x, hdr_src_y}, 8'b01_10_11_00);
        check("t1_vc_tag", {hdr_vc, hdr_tag}, {2'd1, 6'h05});
        idle(1);
        check("t1_hdr_pulse_end", hdr_valid, 0);
        idle(3);
        check("t1_no_beats", beat_n - b0, 0);
        check("t1_no_err", err_n - e0, 0);

        // ---- length 4, clean ----
        b0 = beat_n; e0 = err_n;
        send(1'b0, 1'b0, mk_hdr(8'h82, 5'd4, 32'h2000, 6'h01));
        for (int i = 0; i < 4; i++) send(1'b1, (i == 3), 64'hA0 + 64'(i));
        idle(4);
        check_burst("t2", b0, 4, 4, 1'b1);
        check("t2_data0", beat_data[b0], 64'hA0);
        check("t2_data3", beat_data[b0 + 3], 64'hA3);
        check("t2_no_err", err_n - e0, 0);
        check("t2_err_count", err_count, 0);

        // ---- length 0 -> 32 beats ----
        b0 = beat_n; e0 = err_n;
        send(1'b0, 1'b0, mk_hdr(8'h82, 5'd0, 32'h2100, 6'h02));
        for (int i = 0; i < 32; i++) send(1'b1, (i == 31), 64'h100 + 64'(i));
        idle(4);
        check_burst("t3", b0, 32, 32, 1'b1);
        check("t3_data31", beat_data[b0 + 31], 64'h11F);
        check("t3_no_err", err_n - e0, 0);

        // ---- length 4, tail on beat 2, then a normal header ----
        b0 = beat_n; e0 = err_n; h0 = hdr_n;
        send(1'b0, 1'b0, mk_hdr(8'h82, 5'd4, 32'h2200, 6'h03));
        send(1'b1, 1'b0, 64'hB0);
        send(1'b1, 1'b1, 64'hB1);
        send(1'b0, 1'b1, mk_hdr(8'h01, 5'd0, 32'h3000, 6'h04));
        idle(4);
        check_burst("t4", b0, 2, 2, 1'b1);
        check("t4_err_n", err_n - e0, 1);
        check("t4_err_code", err_code_last, 1);
        check("t4_err_count", err_count, 1);
        check("t4_hdr_n", hdr_n - h0, 2);
        check("t4_next_hdr", hdr_addr_last, 32'h3000);

        // ---- length 2, tail only on flit 5 ----
        b0 = beat_n; e0 = err_n;
        send(1'b0, 1'b0, mk_hdr(8'h82, 5'd2, 32'h2300, 6'h05));
        for (int i = 0; i < 5; i++) send(1'b1, (i == 4), 64'hC0 + 64'(i));
        send(1'b0, 1'b1, mk_hdr(8'h01, 5'd0, 32'h4000, 6'h06));
        idle(4);
        check_burst("t5", b0, 2, 2, 1'b1);
        check("t5_err_n", err_n - e0, 1);
        check("t5_err_code", err_code_last, 1);
        check("t5_err_count", err_count, 2);
        check("t5_next_hdr", hdr_addr_last, 32'h4000);

        // ---- stray payload in IDLE, header stall under hdr_ready = 0 ----
        e0 = err_n; h0 = hdr_n;
        hdr_ready = 1'b0;
        send(1'b1, 1'b1, 64'hDEAD);
        send(1'b0, 1'b1, mk_hdr(8'h01, 5'd0, 32'h5000, 6'h07));
        flit_valid = 1'b1;
        flit_type  = 1'b0;
        flit_tail  = 1'b1;
        flit_data  = mk_hdr(8'h01, 5'd0, 32'h6000, 6'h08);
        stalls = 0;
        repeat (10) begin
            @(negedge clk);
            if (!flit_ready) stalls++;
        end
        check("t6_stall_cycles", stalls, 10);
        @(posedge clk);
        #1;
        check("t6_hdr_held", hdr_address, 32'h5000);
        hdr_ready = 1'b1;
        @(negedge clk);
        check("t6_ready_rises", flit_ready, 1);
        @(posedge clk);
        #1;
        flit_valid = 1'b0;
        check("t6_second_hdr", hdr_address, 32'h6000);
        idle(3);
        check("t6_err_n", err_n - e0, 1);
        check("t6_err_code", err_code_last, 0);
        check("t6_err_count", err_count, 3);
        check("t6_hdr_n", hdr_n - h0, 2);

        // ---- stray header during payload ----
        b0 = beat_n; e0 = err_n;
        send(1'b0, 1'b0, mk_hdr(8'h82, 5'd2, 32'h7000, 6'h09));
        send(1'b1, 1'b0, 64'hD0);
        send(1'b0, 1'b1, mk_hdr(8'h01, 5'd0, 32'h7100, 6'h0A));
        send(1'b1, 1'b1, 64'hD1);
        idle(4);
        check_burst("t7", b0, 2, 2, 1'b0);
        check("t7_err_code", err_code_last, 3);
        check("t7_err_count", err_count, 4);

        // ---- malformed headers ----
        b0 = beat_n; e0 = err_n; h0 = hdr_n;
        send(1'b0, 1'b0, mk_hdr(8'h01, 5'd0, 32'h8000, 6'h0B));
        send(1'b1, 1'b0, 64'hE0);
        send(1'b1, 1'b1, 64'hE1);
        send(1'b0, 1'b1, mk_hdr(8'h82, 5'd2, 32'h8100, 6'h0C));
        idle(3);
        check("t8_err_n", err_n - e0, 2);
        check("t8_err_code", err_code_last, 2);
        check("t8_err_count", err_count, 6);
        check("t8_no_hdr", hdr_n - h0, 0);
        check("t8_no_beats", beat_n - b0, 0);
        send(1'b0, 1'b1, mk_hdr(8'h01, 5'd0, 32'h9000, 6'h0D));
        idle(3);
        check("t8_recover_hdr", hdr_addr_last, 32'h9000);

        // ---- reset mid-packet ----
        send(1'b0, 1'b0, mk_hdr(8'h82, 5'd4, 32'hA000, 6'h0E));
        send(1'b1, 1'b0, 64'hF0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t9_pld_valid", pld_valid, 0);
        check("t9_err_count", err_count, 0);
        check("t9_hdr_address", hdr_address, 0);
        b0 = beat_n; e0 = err_n;
        send(1'b1, 1'b1, 64'hF1);
        idle(3);
        check("t9_stray_err_n", err_n - e0, 1);
        check("t9_stray_code", err_code_last, 0);
        check("t9_no_beats", beat_n - b0, 0);
        check("t9_err_count_after", err_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_noc_packet_unpacker
`default_nettype wire
